tri_edge_raster: RTL and testbench

- Parametrised triangle edge rasterizer for the gpu pipeline; the next generation of the vertex/edge-walk stage.
- Accepts three 2D vertices and sorts them by x.
- Walks the three triangle edges with an all-octant integer Bresenham stepper and streams one edge pixel per cycle over a valid/ready interface.
- Feeds the span/fill stage downstream.

---
 rtl/tri_edge_raster.sv | 176 +++++++++++++++++
 tb/tb_tri_edge_raster.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/tri_edge_raster.sv
// Triangle edge rasterizer: sorts three vertices by x, then walks edges
// S0->S1, S1->S2, S0->S2 with a Bresenham stepper, one pixel per handshake.
module tri_edge_raster #(
  parameter int COORD_W = 4,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] v0x,
  input  logic [COORD_W-1:0] v0y,
  input  logic [COORD_W-1:0] v1x,
  input  logic [COORD_W-1:0] v1y,
  input  logic [COORD_W-1:0] v2x,
  input  logic [COORD_W-1:0] v2y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [1:0]         out_edge,
  output logic               out_last,
  output logic               done,
  output logic [CNT_W-1:0]   pix_count
);
  localparam int EW = COORD_W + 2;

  typedef enum logic [2:0] {IDLE, SORT, SETUP, WALK, DONE} state_t;

  state_t                      state_q;
  logic [2:0][COORD_W-1:0]     vx_q, vy_q;
  logic [1:0]                  edge_q;
  logic [COORD_W-1:0]          dx_q, dy_q, xb_q, yb_q, cx_q, cy_q;
  logic                        syneg_q;
  logic signed [EW-1:0]        err_q;
  logic                        in_ready_q, out_valid_q, out_last_q, done_q;
  logic [CNT_W-1:0]            pix_q;

  // Stable sort: bubble passes (0,1),(1,2),(0,1) swapping only on strict >.
  logic [2:0][COORD_W-1:0] sx, sy;
  logic [COORD_W-1:0]      tx, ty;
  always_comb begin
    sx = vx_q;
    sy = vy_q;
    tx = '0;
    ty = '0;
    if (sx[0] > sx[1]) begin
      tx = sx[0]; ty = sy[0]; sx[0] = sx[1]; sy[0] = sy[1]; sx[1] = tx; sy[1] = ty;
    end
    if (sx[1] > sx[2]) begin
      tx = sx[1]; ty = sy[1]; sx[1] = sx[2]; sy[1] = sy[2]; sx[2] = tx; sy[2] = ty;
    end
    if (sx[0] > sx[1]) begin
      tx = sx[0]; ty = sy[0]; sx[0] = sx[1]; sy[0] = sy[1]; sx[1] = tx; sy[1] = ty;
    end
  end

  // Edge setup from the sorted vertices held in vx_q/vy_q.
  logic [1:0]           ia, ib;
  logic [COORD_W-1:0]   xa, ya, xb, yb, dx_s, dy_s;
  logic signed [EW-1:0] err_s;
  always_comb begin
    ia    = (edge_q == 2'd1) ? 2'd1 : 2'd0;
    ib    = (edge_q == 2'd0) ? 2'd1 : 2'd2;
    xa    = vx_q[ia];
    ya    = vy_q[ia];
    xb    = vx_q[ib];
    yb    = vy_q[ib];
    dx_s  = xb - xa;
    dy_s  = (yb >= ya) ? (yb - ya) : (ya - yb);
    err_s = $signed({2'b00, dx_s}) - $signed({2'b00, dy_s});
  end

  // One Bresenham step; both decisions use the pre-step error.
  logic signed [EW:0]   e2, dxe, dye, errn;
  logic                 step_x, step_y, at_end, next_end;
  logic [COORD_W-1:0]   nx, ny;
  always_comb begin
    e2       = {err_q, 1'b0};
    dxe      = $signed({3'b000, dx_q});
    dye      = $signed({3'b000, dy_q});
    step_x   = (e2 >= -dye);
    step_y   = (e2 <= dxe);
    errn     = $signed({err_q[EW-1], err_q}) + (step_y ? dxe : '0) - (step_x ? dye : '0);
    nx       = step_x ? cx_q + COORD_W'(1) : cx_q;
    ny       = !step_y ? cy_q : (syneg_q ? cy_q - COORD_W'(1) : cy_q + COORD_W'(1));
    at_end   = (cx_q == xb_q) && (cy_q == yb_q);
    next_end = (nx == xb_q) && (ny == yb_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vx_q        <= '0;
      vy_q        <= '0;
      edge_q      <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      xb_q        <= '0;
      yb_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      syneg_q     <= 1'b0;
      err_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      pix_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          vx_q       <= {v2x, v1x, v0x};
          vy_q       <= {v2y, v1y, v0y};
          pix_q      <= '0;
          edge_q     <= 2'd0;
          in_ready_q <= 1'b0;
          state_q    <= SORT;
        end
        SORT: begin
          vx_q    <= sx;
          vy_q    <= sy;
          state_q <= SETUP;
        end
        SETUP: begin
          dx_q        <= dx_s;
          dy_q        <= dy_s;
          syneg_q     <= (yb < ya);
          err_q       <= err_s;
          xb_q        <= xb;
          yb_q        <= yb;
          cx_q        <= xa;
          cy_q        <= ya;
          out_valid_q <= 1'b1;
          out_last_q  <= (edge_q == 2'd2) && (xa == xb) && (ya == yb);
          state_q     <= WALK;
        end
        WALK: if (out_ready) begin
          pix_q <= pix_q + CNT_W'(1);
          if (at_end) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (edge_q == 2'd2) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              edge_q  <= edge_q + 2'd1;
              state_q <= SETUP;
            end
          end else begin
            cx_q       <= nx;
            cy_q       <= ny;
            err_q      <= errn[EW-1:0];
            out_last_q <= (edge_q == 2'd2) && next_end;
          end
        end
        DONE: begin
          done_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_x     = cx_q;
  assign out_y     = cy_q;
  assign out_edge  = edge_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign pix_count = pix_q;

endmodule

// File: tb/tb_tri_edge_raster.sv
// Directed bench for tri_edge_raster: per-triangle expected pixel streams,
// plus backpressure and mid-walk reset sequences.
module tb_tri_edge_raster;
  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [3:0] v0x = '0, v0y = '0, v1x = '0, v1y = '0, v2x = '0, v2y = '0;
  logic [3:0] out_x, out_y;
  logic [1:0] out_edge;
  logic       out_last, done;
  logic [6:0] pix_count;

  tri_edge_raster dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_edge(out_edge), .out_last(out_last), .done(done), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int e; int l; } pix_t;
  typedef struct { int ax; int ay; int bx; int by; int cx; int cy; int first; int npix; } tri_t;

  pix_t ep[64];
  tri_t tr[4];
  int   np = 0;
  int   total = 0, bad = 0;

  task automatic addp(input int x, input int y, input int e, input int l);
    ep[np] = '{x, y, e, l};
    np++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run_tri(input int t, input int stall_k);
    int cyc, k, stalls, bub;
    pix_t p;
    @(negedge clk);
    {v0x, v0y, v1x, v1y, v2x, v2y} = {4'(tr[t].ax), 4'(tr[t].ay), 4'(tr[t].bx),
                                      4'(tr[t].by), 4'(tr[t].cx), 4'(tr[t].cy)};
    in_valid = 1'b1;
    chk($sformatf("t%0d in_ready idle", t), int'(in_ready), 1);
    @(negedge clk);
    in_valid = (stall_k >= 0);
    if (stall_k >= 0) {v0x, v0y, v1x, v1y, v2x, v2y} = {6{4'hf}};
    chk($sformatf("t%0d in_ready busy", t), int'(in_ready), 0);
    cyc = 1;
    while (!out_valid && cyc < 10) begin @(negedge clk); cyc++; end
    chk($sformatf("t%0d latency", t), cyc, 3);
    k = 0; stalls = 0; bub = 0;
    while (k < tr[t].npix && cyc < 300) begin
      p = ep[tr[t].first + k];
      if (out_valid) begin
        if (k == stall_k && stalls < 4) begin
          out_ready = 1'b0;
          stalls++;
          chk($sformatf("t%0d hold%0d xy", t, stalls), int'({out_x, out_y}), p.x * 16 + p.y);
          chk($sformatf("t%0d hold%0d edge", t, stalls), int'(out_edge), p.e);
        end else begin
          out_ready = 1'b1;
          chk($sformatf("t%0d p%0d x", t, k), int'(out_x), p.x);
          chk($sformatf("t%0d p%0d y", t, k), int'(out_y), p.y);
          chk($sformatf("t%0d p%0d edge", t, k), int'(out_edge), p.e);
          chk($sformatf("t%0d p%0d last", t, k), int'(out_last), p.l);
          k++;
        end
      end else bub++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk($sformatf("t%0d pixels before timeout", t), k, tr[t].npix);
    chk($sformatf("t%0d bubbles", t), bub, 2);
    chk($sformatf("t%0d done pulse", t), int'(done), 1);
    chk($sformatf("t%0d valid after", t), int'(out_valid), 0);
    chk($sformatf("t%0d in_ready in DONE", t), int'(in_ready), 0);
    chk($sformatf("t%0d pix_count", t), int'(pix_count), tr[t].npix);
    @(negedge clk);
    chk($sformatf("t%0d done drop", t), int'(done), 0);
    chk($sformatf("t%0d in_ready back", t), int'(in_ready), 1);
    chk($sformatf("t%0d pix_count hold", t), int'(pix_count), tr[t].npix);
  endtask

  initial begin
    int cyc;
    // collinear (5,2),(1,2),(3,2)
    tr[0] = '{5, 2, 1, 2, 3, 2, np, 11};
    for (int x = 1; x <= 3; x++) addp(x, 2, 0, 0);
    for (int x = 3; x <= 5; x++) addp(x, 2, 1, 0);
    for (int x = 1; x <= 5; x++) addp(x, 2, 2, int'(x == 5));
    // steep (0,0),(3,1),(1,3)
    tr[1] = '{0, 0, 3, 1, 1, 3, np, 11};
    addp(0, 0, 0, 0); addp(0, 1, 0, 0); addp(1, 2, 0, 0); addp(1, 3, 0, 0);
    addp(1, 3, 1, 0); addp(2, 2, 1, 0); addp(3, 1, 1, 0);
    addp(0, 0, 2, 0); addp(1, 0, 2, 0); addp(2, 1, 2, 0); addp(3, 1, 2, 1);
    // stable tie, negative slope (2,5),(2,1),(0,0)
    tr[2] = '{2, 5, 2, 1, 0, 0, np, 14};
    addp(0, 0, 0, 0); addp(0, 1, 0, 0); addp(1, 2, 0, 0);
    addp(1, 3, 0, 0); addp(2, 4, 0, 0); addp(2, 5, 0, 0);
    for (int y = 5; y >= 1; y--) addp(2, y, 1, 0);
    addp(0, 0, 2, 0); addp(1, 1, 2, 0); addp(2, 1, 2, 1);
    // fully degenerate (7,7)
    tr[3] = '{7, 7, 7, 7, 7, 7, np, 3};
    addp(7, 7, 0, 0); addp(7, 7, 1, 0); addp(7, 7, 2, 1);

    repeat (2) @(negedge clk);
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_xy", int'({out_x, out_y}), 0);
    chk("rst edge/last/done", int'({out_edge, out_last, done}), 0);
    chk("rst pix_count", int'(pix_count), 0);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) run_tri(t, -1);
    run_tri(2, 8);  // stall 4 cycles mid edge 1, in_valid held high with junk

    // Reset in the middle of edge 1
    @(negedge clk);
    {v0x, v0y, v1x, v1y, v2x, v2y} = {4'd5, 4'd2, 4'd1, 4'd2, 4'd3, 4'd2};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!(out_valid && out_edge == 2'd1 && out_x == 4'd4) && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    chk("reach edge1 mid", int'(cyc < 50), 1);
    rst = 1'b1;
    #1;
    chk("mid rst out_valid", int'(out_valid), 0);
    chk("mid rst in_ready", int'(in_ready), 1);
    chk("mid rst pix_count", int'(pix_count), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("post rst out_valid", int'(out_valid), 0);
    run_tri(2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
